// File: rtl/sumador_param_if.sv
// Control/step inputs and count/flag outputs of the sumador_param counter.
// The master side drives the controls; the slave side is the counter itself.
interface sumador_param_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STEP_W = 4
);
  logic              enable;
  logic              load;
  logic [WIDTH-1:0]  load_val;
  logic [STEP_W-1:0] step;
  logic              dir;
  logic              sat_mode;
  logic [WIDTH-1:0]  out;
  logic              cout;
  logic              sat;
  logic              zero;

  modport master (
    output enable, load, load_val, step, dir, sat_mode,
    input  out, cout, sat, zero
  );

  modport slave (
    input  enable, load, load_val, step, dir, sat_mode,
    output out, cout, sat, zero
  );
endinterface

// File: rtl/sumador_param.sv
// WIDTH-bit accumulating counter: programmable step, up/down, wrap or saturate,
// synchronous load; registered carry/borrow pulse, saturation and zero flags.
module sumador_param #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STEP_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  sumador_param_if.slave  bus
);

  generate
    if (WIDTH < 2 || STEP_W < 1 || STEP_W > WIDTH) begin : g_param_check
      $error("sumador_param: need WIDTH >= 2 and 1 <= STEP_W <= WIDTH");
    end
  endgenerate

  logic [WIDTH-1:0] out_q, out_d;
  logic             cout_q, cout_d;
  logic             sat_q, sat_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] step_ext;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;

  // The extra top bit of sum/diff is the carry, or the borrow (step > out).
  always_comb begin
    step_ext = WIDTH'(bus.step);
    sum      = {1'b0, out_q} + {1'b0, step_ext};
    diff     = {1'b0, out_q} - {1'b0, step_ext};
    out_d    = out_q;
    cout_d   = 1'b0;
    sat_d    = sat_q;
    zero_d   = zero_q;

    if (bus.load) begin
      out_d  = bus.load_val;
      sat_d  = 1'b0;
      zero_d = (bus.load_val == '0);
    end else if (bus.enable) begin
      sat_d = 1'b0;
      if (!bus.dir) begin
        out_d  = sum[WIDTH-1:0];
        cout_d = sum[WIDTH];
        if (sum[WIDTH] && bus.sat_mode) begin
          out_d = '1;
          sat_d = 1'b1;
        end
      end else begin
        out_d  = diff[WIDTH-1:0];
        cout_d = diff[WIDTH];
        if (diff[WIDTH] && bus.sat_mode) begin
          out_d = '0;
          sat_d = 1'b1;
        end
      end
      zero_d = (out_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= '0;
      cout_q <= 1'b0;
      sat_q  <= 1'b0;
      zero_q <= 1'b1;
    end else begin
      out_q  <= out_d;
      cout_q <= cout_d;
      sat_q  <= sat_d;
      zero_q <= zero_d;
    end
  end

  assign bus.out  = out_q;
  assign bus.cout = cout_q;
  assign bus.sat  = sat_q;
  assign bus.zero = zero_q;

endmodule

// File: tb/tb_sumador_param.sv
// Bench for sumador_param: directed literal checks on the 8/4-bit counter plus a
// random run of 4-, 8- and 12-bit counters against an integer-arithmetic model.
module tb_sumador_param;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sumador_param_if #(.WIDTH(4),  .STEP_W(4)) if4 ();
  sumador_param_if #(.WIDTH(8),  .STEP_W(4)) if8 ();
  sumador_param_if #(.WIDTH(12), .STEP_W(6)) if12 ();

  sumador_param #(.WIDTH(4),  .STEP_W(4)) u4  (.clk(clk), .rst(rst), .bus(if4.slave));
  sumador_param #(.WIDTH(8),  .STEP_W(4)) u8  (.clk(clk), .rst(rst), .bus(if8.slave));
  sumador_param #(.WIDTH(12), .STEP_W(6)) u12 (.clk(clk), .rst(rst), .bus(if12.slave));

  int n_pass  = 0;
  int n_total = 0;

  // Stimulus as seen by the model (already truncated to each counter's widths)
  int wid   [3] = '{4, 8, 12};
  int stw   [3] = '{4, 4, 6};
  bit s_rst, s_load, s_en, s_dir, s_satm;
  int s_lv  [3];
  int s_st  [3];

  int m_out [3];
  bit m_cout[3];
  bit m_sat [3];
  bit m_zero[3];
  bit started = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference: plain integer arithmetic against the numeric bounds 0 and 2^W-1
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      int maxv;
      int v;
      maxv = (1 << wid[i]) - 1;
      if (s_rst) begin
        m_out[i] = 0; m_cout[i] = 0; m_sat[i] = 0; m_zero[i] = 1;
      end else if (s_load) begin
        m_out[i] = s_lv[i]; m_cout[i] = 0; m_sat[i] = 0; m_zero[i] = (s_lv[i] == 0);
      end else if (s_en) begin
        if (!s_dir) v = m_out[i] + s_st[i];
        else        v = m_out[i] - s_st[i];
        if (v > maxv || v < 0) begin
          m_cout[i] = 1;
          m_sat[i]  = s_satm;
          if (s_satm) m_out[i] = (v > maxv) ? maxv : 0;
          else        m_out[i] = (v > maxv) ? v - (maxv + 1) : v + (maxv + 1);
        end else begin
          m_cout[i] = 0; m_sat[i] = 0; m_out[i] = v;
        end
        m_zero[i] = (m_out[i] == 0);
      end else begin
        m_cout[i] = 0;
      end
    end
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      check("w4.out",   int'(if4.out),  m_out[0]);
      check("w4.cout",  int'(if4.cout), int'(m_cout[0]));
      check("w4.sat",   int'(if4.sat),  int'(m_sat[0]));
      check("w4.zero",  int'(if4.zero), int'(m_zero[0]));
      check("w8.out",   int'(if8.out),  m_out[1]);
      check("w8.cout",  int'(if8.cout), int'(m_cout[1]));
      check("w8.sat",   int'(if8.sat),  int'(m_sat[1]));
      check("w8.zero",  int'(if8.zero), int'(m_zero[1]));
      check("w12.out",  int'(if12.out),  m_out[2]);
      check("w12.cout", int'(if12.cout), int'(m_cout[2]));
      check("w12.sat",  int'(if12.sat),  int'(m_sat[2]));
      check("w12.zero", int'(if12.zero), int'(m_zero[2]));
    end
  end

  task automatic drive(input bit r, input bit l, input bit e, input bit d, input bit sm,
                       input int unsigned lv, input int unsigned st);
    s_rst = r; s_load = l; s_en = e; s_dir = d; s_satm = sm;
    for (int i = 0; i < 3; i++) begin
      s_lv[i] = int'(lv & ((32'd1 << wid[i]) - 1));
      s_st[i] = int'(st & ((32'd1 << stw[i]) - 1));
    end
    rst = r;
    if4.load = l;  if4.enable = e;  if4.dir = d;  if4.sat_mode = sm;
    if8.load = l;  if8.enable = e;  if8.dir = d;  if8.sat_mode = sm;
    if12.load = l; if12.enable = e; if12.dir = d; if12.sat_mode = sm;
    if4.load_val  = 4'(s_lv[0]);  if4.step  = 4'(s_st[0]);
    if8.load_val  = 8'(s_lv[1]);  if8.step  = 4'(s_st[1]);
    if12.load_val = 12'(s_lv[2]); if12.step = 6'(s_st[2]);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic exp8(input string name, input int o, input bit c, input bit s, input bit z);
    check({name, ".out"},  int'(if8.out),  o);
    check({name, ".cout"}, int'(if8.cout), int'(c));
    check({name, ".sat"},  int'(if8.sat),  int'(s));
    check({name, ".zero"}, int'(if8.zero), int'(z));
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    exp8("reset", 8'h00, 0, 0, 1);

    // Plain count by 1
    drive(0, 0, 1, 0, 0, 0, 1);
    tick(); exp8("cnt1", 8'h01, 0, 0, 0);
    tick(); exp8("cnt2", 8'h02, 0, 0, 0);
    tick(); exp8("cnt3", 8'h03, 0, 0, 0);

    // Wrap carry
    drive(0, 1, 0, 0, 0, 32'hFE, 0); tick(); exp8("ldFE", 8'hFE, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0, 3);      tick(); exp8("wrap", 8'h01, 1, 0, 0);
    tick(); exp8("wrap_next", 8'h04, 0, 0, 0);

    // Saturation up, hold at max, then down
    drive(0, 1, 0, 0, 1, 32'hFD, 0); tick(); exp8("ldFD", 8'hFD, 0, 0, 0);
    drive(0, 0, 1, 0, 1, 0, 5);      tick(); exp8("satup", 8'hFF, 1, 1, 0);
    tick(); exp8("satup2", 8'hFF, 1, 1, 0);
    drive(0, 0, 1, 1, 1, 0, 2);      tick(); exp8("dn2", 8'hFD, 0, 0, 0);
    drive(0, 1, 0, 0, 1, 32'h02, 0); tick(); exp8("ld02", 8'h02, 0, 0, 0);
    drive(0, 0, 1, 1, 1, 0, 7);      tick(); exp8("satdn", 8'h00, 1, 1, 1);

    // Borrow wrap and exact bound landing
    drive(0, 1, 0, 0, 0, 32'h03, 0); tick();
    drive(0, 0, 1, 1, 0, 0, 5);      tick(); exp8("borrow", 8'hFE, 1, 0, 0);
    drive(0, 1, 0, 0, 0, 32'hFC, 0); tick();
    drive(0, 0, 1, 0, 0, 0, 3);      tick(); exp8("exact", 8'hFF, 0, 0, 0);

    // Priority and hold
    drive(0, 1, 1, 0, 0, 32'h55, 3); tick(); exp8("ld_over_en", 8'h55, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 3);
    for (int k = 0; k < 3; k++) begin
      tick(); exp8("hold", 8'h55, 0, 0, 0);
    end
    drive(1, 1, 0, 0, 0, 32'h55, 0); tick(); exp8("rst_over_ld", 8'h00, 0, 0, 1);

    // 4-bit wrap to zero
    drive(0, 1, 0, 0, 0, 32'h1, 0);  tick();
    drive(0, 0, 1, 0, 0, 0, 15);     tick();
    check("w4_wrap.out",  int'(if4.out),  0);
    check("w4_wrap.cout", int'(if4.cout), 1);
    check("w4_wrap.zero", int'(if4.zero), 1);

    // Random run; load values biased toward the top of the range
    for (int n = 0; n < 600; n++) begin
      int unsigned lv;
      lv = ($urandom_range(0, 2) == 0) ? (32'hFFFF_FFFF - $urandom_range(0, 3)) : $urandom;
      drive($urandom_range(0, 60) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), lv, $urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
